// File: rtl/unidade_controle.sv
// unidade_controle -- multicycle control unit for the RV64 datapath (UP).
//
// Sequences fetch, decode, execute, memory and write-back. All outputs are
// decoded from the state register (Moore). The one exception is PCwrite in
// BRANCH, which follows the ALU flags combinationally.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   opcode, funct3, funct7   : instruction fields from IR
//   AluIgual, AluMenor       : ALU comparison flags (A==B, A<B signed)
//   PCwrite, LoadIR, RegWrite, loadRegA, loadRegB,
//   loadRegAluOut, loadRegMemData : datapath load enables
//   DMemWrite                : data memory write (0 = read)
//   SelMuxA/B/Mem, SelMuxPC  : datapath mux selects
//   AluOperation             : 000 load, 001 add, 010 sub, 011 and, 111 compare
//   state_out                : current state code
//   halted                   : FSM is in HALT
//   illegal                  : HALT was entered on an unsupported instruction
module unidade_controle (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       AluIgual,
  input  logic       AluMenor,
  output logic       PCwrite,
  output logic       LoadIR,
  output logic       RegWrite,
  output logic       loadRegA,
  output logic       loadRegB,
  output logic       loadRegAluOut,
  output logic       loadRegMemData,
  output logic       DMemWrite,
  output logic [2:0] SelMuxA,
  output logic [2:0] SelMuxB,
  output logic [2:0] SelMuxMem,
  output logic       SelMuxPC,
  output logic [2:0] AluOperation,
  output logic [4:0] state_out,
  output logic       halted,
  output logic       illegal
);

  localparam logic [4:0] RESET      = 5'd0;
  localparam logic [4:0] FETCH      = 5'd1;
  localparam logic [4:0] FETCH_WAIT = 5'd2;
  localparam logic [4:0] DECODE     = 5'd3;
  localparam logic [4:0] EXEC_R     = 5'd4;
  localparam logic [4:0] EXEC_I     = 5'd5;
  localparam logic [4:0] ALU_WB     = 5'd6;
  localparam logic [4:0] MEM_ADDR   = 5'd7;
  localparam logic [4:0] LD_READ    = 5'd8;
  localparam logic [4:0] LD_WAIT    = 5'd9;
  localparam logic [4:0] LD_WB      = 5'd10;
  localparam logic [4:0] SD_WRITE   = 5'd11;
  localparam logic [4:0] BRANCH     = 5'd12;
  localparam logic [4:0] JAL        = 5'd13;
  localparam logic [4:0] LUI_WB     = 5'd14;
  localparam logic [4:0] HALT       = 5'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  logic [4:0] state;
  logic [4:0] nextState;
  logic       setIllegal;
  logic       illegalReg;
  logic       branchTaken;
  logic       isAdd;
  logic       isSub;
  logic       isAnd;

  assign isAdd = (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign isSub = (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign isAnd = (funct3 == 3'b111) && (funct7 == 7'b0000000);

  always_comb begin
    case (funct3)
      3'b000:  branchTaken = AluIgual;
      3'b001:  branchTaken = !AluIgual;
      3'b100:  branchTaken = AluMenor;
      3'b101:  branchTaken = !AluMenor;
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state logic. setIllegal marks a transition into HALT caused by an
  // unsupported encoding (break reaches HALT without it).
  always_comb begin
    nextState  = state;
    setIllegal = 1'b0;
    case (state)
      RESET:      nextState = FETCH;
      FETCH:      nextState = FETCH_WAIT;
      FETCH_WAIT: nextState = DECODE;
      DECODE: begin
        if (opcode == OP_R)
          nextState = EXEC_R;
        else if (opcode == OP_IMM && funct3 == 3'b000)
          nextState = EXEC_I;
        else if ((opcode == OP_LOAD && funct3 == 3'b011) ||
                 (opcode == OP_STORE && funct3 == 3'b111))
          nextState = MEM_ADDR;
        else if (opcode == OP_BRANCH &&
                 (funct3 == 3'b000 || funct3 == 3'b001 ||
                  funct3 == 3'b100 || funct3 == 3'b101))
          nextState = BRANCH;
        else if (opcode == OP_JAL)
          nextState = JAL;
        else if (opcode == OP_LUI)
          nextState = LUI_WB;
        else if (opcode == 7'b1110011)
          nextState = HALT;
        else begin
          nextState  = HALT;
          setIllegal = 1'b1;
        end
      end
      EXEC_R: begin
        if (isAdd || isSub || isAnd)
          nextState = ALU_WB;
        else begin
          nextState  = HALT;
          setIllegal = 1'b1;
        end
      end
      EXEC_I:   nextState = ALU_WB;
      ALU_WB:   nextState = FETCH;
      MEM_ADDR: nextState = (opcode == OP_LOAD) ? LD_READ : SD_WRITE;
      LD_READ:  nextState = LD_WAIT;
      LD_WAIT:  nextState = LD_WB;
      LD_WB:    nextState = FETCH;
      SD_WRITE: nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JAL:      nextState = FETCH;
      LUI_WB:   nextState = FETCH;
      HALT:     nextState = HALT;
      default:  nextState = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET;
      illegalReg <= 1'b0;
    end else begin
      state <= nextState;
      if (setIllegal)
        illegalReg <= 1'b1;
    end
  end

  // Output decode: everything defaults to 0 and each state raises only
  // what it needs.
  always_comb begin
    PCwrite        = 1'b0;
    LoadIR         = 1'b0;
    RegWrite       = 1'b0;
    loadRegA       = 1'b0;
    loadRegB       = 1'b0;
    loadRegAluOut  = 1'b0;
    loadRegMemData = 1'b0;
    DMemWrite      = 1'b0;
    SelMuxA        = 3'd0;
    SelMuxB        = 3'd0;
    SelMuxMem      = 3'd0;
    SelMuxPC       = 1'b0;
    AluOperation   = 3'b000;
    case (state)
      FETCH: begin
        SelMuxA       = 3'd0;
        SelMuxB       = 3'd1;
        AluOperation  = ALU_ADD;
        loadRegAluOut = 1'b1;
      end
      FETCH_WAIT: LoadIR = 1'b1;
      DECODE: begin
        // PC takes the old AluOut (PC+4) on the same edge AluOut takes the
        // branch/jal target.
        PCwrite       = 1'b1;
        SelMuxPC      = 1'b1;
        SelMuxA       = 3'd0;
        SelMuxB       = 3'd2;
        AluOperation  = ALU_ADD;
        loadRegAluOut = 1'b1;
        loadRegA      = 1'b1;
        loadRegB      = 1'b1;
      end
      EXEC_R: begin
        SelMuxA       = 3'd1;
        SelMuxB       = 3'd0;
        loadRegAluOut = 1'b1;
        if (isAdd)      AluOperation = ALU_ADD;
        else if (isSub) AluOperation = ALU_SUB;
        else if (isAnd) AluOperation = ALU_AND;
        else            AluOperation = 3'b000;
      end
      EXEC_I, MEM_ADDR: begin
        SelMuxA       = 3'd1;
        SelMuxB       = 3'd2;
        AluOperation  = ALU_ADD;
        loadRegAluOut = 1'b1;
      end
      ALU_WB: begin
        SelMuxMem = 3'd0;
        RegWrite  = 1'b1;
      end
      LD_WAIT: loadRegMemData = 1'b1;
      LD_WB: begin
        SelMuxMem = 3'd1;
        RegWrite  = 1'b1;
      end
      SD_WRITE: DMemWrite = 1'b1;
      BRANCH: begin
        SelMuxA      = 3'd1;
        SelMuxB      = 3'd0;
        AluOperation = ALU_CMP;
        SelMuxPC     = 1'b1;
        PCwrite      = branchTaken;
      end
      JAL: begin
        SelMuxMem = 3'd3;
        RegWrite  = 1'b1;
        PCwrite   = 1'b1;
        SelMuxPC  = 1'b1;
      end
      LUI_WB: begin
        SelMuxMem = 3'd2;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state;
  assign halted    = (state == HALT);
  assign illegal   = illegalReg;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the RV64 datapath (`UP`): a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back. It drives every mux select, register load enable, memory write and ALU opcode of the datapath. It reads back only the instruction fields and the ALU comparison flags. It sits beside the datapath inside the CPU top level and replaces the ad-hoc control stimulus used in simulation.

## Interface
- No parameters; state encoding and signal encodings are fixed below.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7` in 7: IR[31:25].
- `AluIgual` in 1: ALU A==B flag, combinational.
- `AluMenor` in 1: ALU A<B (signed) flag, combinational.
- `PCwrite`, `LoadIR`, `RegWrite`, `loadRegA`, `loadRegB`, `loadRegAluOut`, `loadRegMemData` out 1: datapath load enables.
- `DMemWrite` out 1: data memory write (0 = read).
- `SelMuxA` out 3: ALU A source. 0 = PC, 1 = RegA.
- `SelMuxB` out 3: ALU B source. 0 = RegB, 1 = constant 4, 2 = sign-extended immediate. The immediate is decoded by the datapath from the opcode; branch and jal immediates are byte offsets.
- `SelMuxMem` out 3: register-file write data. 0 = AluOut, 1 = MemDataReg, 2 = immediate (lui), 3 = PC.
- `SelMuxPC` out 1: PC source. 0 = ALU result, 1 = AluOut.
- `AluOperation` out 3: 000 load, 001 add, 010 sub, 011 and, 111 compare.
- `state_out` out 5: current state code.
- `halted` out 1: FSM is in HALT.
- `illegal` out 1: HALT was entered on an unsupported instruction.

## Operation
- Outputs are decoded from the state register. Every output is 0 unless listed for the current state. `PCwrite` in BRANCH is the only Mealy output.
- State codes: RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_R=4, EXEC_I=5, ALU_WB=6, MEM_ADDR=7, LD_READ=8, LD_WAIT=9, LD_WB=10, SD_WRITE=11, BRANCH=12, JAL=13, LUI_WB=14, HALT=15.
- RESET: all outputs 0. Next state FETCH.
- FETCH: instruction memory addressed by PC. `SelMuxA`=0, `SelMuxB`=1, `AluOperation`=001, `loadRegAluOut`=1, so AluOut←PC+4. Next state FETCH_WAIT.
- FETCH_WAIT: `LoadIR`=1. Next state DECODE.
- DECODE:
  - `PCwrite`=1 with `SelMuxPC`=1, so PC←PC+4.
  - `SelMuxA`=0, `SelMuxB`=2, add, `loadRegAluOut`=1, so AluOut←old PC+imm, which is the branch/jal target.
  - `loadRegA`=`loadRegB`=1.
  - Dispatch on opcode:
    - 0110011 → EXEC_R
    - 0010011 with f3=000 → EXEC_I
    - 0000011 with f3=011 (ld), or 0100011 with f3=111 (sd) → MEM_ADDR
    - 1100011 with f3 ∈ {000, 001, 100, 101} → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI_WB
    - anything else → HALT with `illegal`←1
- EXEC_R: `SelMuxA`=1, `SelMuxB`=0, `loadRegAluOut`=1.
  - add: f3=000, f7=0000000, op 001.
  - sub: f3=000, f7=0100000, op 010.
  - and: f3=111, f7=0, op 011.
  - Next state ALU_WB. Any other funct → HALT with `illegal`←1.
- EXEC_I: `SelMuxA`=1, `SelMuxB`=2, add, `loadRegAluOut`=1. Next state ALU_WB.
- ALU_WB: `SelMuxMem`=0, `RegWrite`=1. Next state FETCH.
- MEM_ADDR: `SelMuxA`=1, `SelMuxB`=2, add, `loadRegAluOut`=1. Next state LD_READ for ld, SD_WRITE for sd.
- LD_READ: data memory addressed by AluOut, `DMemWrite`=0. Next state LD_WAIT.
- LD_WAIT: `loadRegMemData`=1. Next state LD_WB.
- LD_WB: `SelMuxMem`=1, `RegWrite`=1. Next state FETCH.
- SD_WRITE: `DMemWrite`=1 for exactly one cycle. Next state FETCH.
- BRANCH: `SelMuxA`=1, `SelMuxB`=0, `AluOperation`=111, `SelMuxPC`=1.
  - `PCwrite` = taken, where beq taken = `AluIgual`, bne = !`AluIgual`, blt = `AluMenor`, bge = !`AluMenor`.
  - Next state FETCH.
- JAL: `SelMuxMem`=3 and `RegWrite`=1 (rd←PC+4); `PCwrite`=1 and `SelMuxPC`=1 (PC←target). Next state FETCH.
- LUI_WB: `SelMuxMem`=2, `RegWrite`=1. Next state FETCH.
- opcode 1110011 (break) and illegal instructions go to HALT.
- HALT: all control outputs 0, `halted`=1. Sticky until `rst`. `illegal` is sticky, and is cleared only by `rst`.

## Timing
- Reset:
  - `rst` sampled high at a rising edge → state=RESET, `illegal`=0.
  - `rst` overrides every transition, including mid-instruction. SD_WRITE aborted by reset writes only during the cycle already in progress.
  - After reset: all outputs 0 and `state_out`=0.
  - The first FETCH is one cycle after `rst` is sampled low.
- Latency in cycles, counted from FETCH through the return to FETCH:
  - R-type and addi: 5
  - ld: 7
  - sd: 5
  - branch, jal, lui: 4
- The instruction and data memories have a one-cycle registered read. Data is captured exactly in the state after the addressing state.
- Same-edge updates in DECODE: PC takes the old AluOut (PC+4) while AluOut takes the target. Both registers load on the same edge.
- Branch flags must be stable within the BRANCH cycle; `PCwrite` follows them combinationally.

## Test plan
- Reset: hold `rst`=1 for 2 cycles mid-ld (state 8) → next state 0, all outputs 0, `illegal`=0; FETCH follows after release.
- add: opcode 0110011, f3=000, f7=0 → states 1,2,3,4,6,1; `AluOperation`=001 in state 4; `RegWrite`=1 only in state 6.
- ld/sd:
  - ld (0000011, f3=011) → states 1,2,3,7,8,9,10,1 with `loadRegMemData`=1 in state 9.
  - sd (0100011, f3=111) → `DMemWrite`=1 for one cycle in state 11.
- Branches in state 12:
  - beq with `AluIgual`=1 → `PCwrite`=1, `SelMuxPC`=1.
  - bne with `AluIgual`=1 → `PCwrite`=0.
  - bge with `AluMenor`=0 → `PCwrite`=1.
- jal/lui:
  - jal → state 13 with `SelMuxMem`=3, `RegWrite`=1, `PCwrite`=1.
  - lui → state 14 with `SelMuxMem`=2.
- Halt:
  - opcode 1110011 → state 15, `halted`=1, `illegal`=0, stays there for 20 cycles.
  - opcode 0000000 → `illegal`=1; cleared by `rst`.
